fetch_stage_ctrl: RTL and testbench

//   IF stage of the 5-stage RV32I pipeline: consumer of the hazard unit's stall/flush controls.

---
 rtl/fetch_stage_ctrl_if.sv | 13 +
 rtl/fetch_stage_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// Instruction-memory request/response bus between the IF stage and imem.
// One request is outstanding at a time; read data returns at least one
// cycle after the request is acknowledged.
interface fetch_stage_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rvalid, rdata);
  modport slave  (input req, addr, output ack, rvalid, rdata);
endinterface

// File: rtl/fetch_stage_ctrl.sv
// IF stage of the 5-stage RV32I pipeline. Owns the PC, runs the
// single-outstanding imem handshake, parks a returned word while the pipe is
// stalled, drives the IF/ID register and discards wrong-path responses after
// a redirect from EX.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_stallF,
  input  logic                       i_stallD,
  input  logic                       i_flushD,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  fetch_stage_ctrl_if.master         imem,
  output logic [6:0]                 o_opcodeF,
  output logic [31:0]                o_instrD,
  output logic [31:0]                o_pcD,
  output logic [31:0]                o_pc4D,
  output logic                       o_validD
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic        drop_q, drop_n;
  logic [31:0] hold_q, hold_n;
  logic [31:0] pc_plus4;
  logic [31:0] word;
  logic        deliver;
  logic        unstalled;
  logic [6:0]  opcode;

  assign pc_plus4  = pc_q + 32'd4;
  assign unstalled = !i_stallF && !i_stallD;

  // The request is only visible in REQ and is masked while reset is held.
  assign imem.req  = (state_q == S_REQ) && !i_reset;
  assign imem.addr = pc_q;
  assign o_opcodeF = opcode;

  // Fetch state register with PC, drop flag and the stall-hold buffer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      drop_q  <= drop_n;
      hold_q  <= hold_n;
    end
  end

  // Next-state, PC advance, delivery and opcode-to-hazard-unit decode.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    drop_n  = drop_q;
    hold_n  = hold_q;
    deliver = 1'b0;
    word    = imem.rdata;
    opcode  = '0;
    case (state_q)
      S_REQ: begin
        if (imem.ack) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          if (drop_q) begin
            // Response belongs to a request issued before a redirect.
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            opcode = imem.rdata[6:0];
            if (unstalled) begin
              deliver = 1'b1;
              pc_n    = pc_plus4;
              state_n = S_REQ;
            end else begin
              hold_n  = imem.rdata;
              state_n = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        word   = hold_q;
        opcode = hold_q[6:0];
        if (unstalled) begin
          deliver = 1'b1;
          pc_n    = pc_plus4;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    // A redirect overrides everything above, including stallF on the PC.
    if (i_redirect) begin
      pc_n    = i_redirect_pc & ~32'd3;
      hold_n  = '0;
      deliver = 1'b0;
      case (state_q)
        S_REQ: begin
          // An address acked this cycle is wrong-path; its data must be dropped.
          state_n = imem.ack ? S_WAIT : S_REQ;
          drop_n  = imem.ack;
        end
        S_WAIT: begin
          opcode = '0;
          if (imem.rvalid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end
        default: begin
          state_n = S_REQ;
          drop_n  = 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: squash beats stall, stall beats load, otherwise a bubble.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_instrD <= NOP_INSTR;
      o_pcD    <= '0;
      o_pc4D   <= '0;
      o_validD <= 1'b0;
    end else if (i_redirect || i_flushD) begin
      o_instrD <= NOP_INSTR;
      o_pcD    <= '0;
      o_pc4D   <= '0;
      o_validD <= 1'b0;
    end else if (i_stallD) begin
      o_instrD <= o_instrD;
      o_pcD    <= o_pcD;
      o_pc4D   <= o_pc4D;
      o_validD <= o_validD;
    end else if (deliver) begin
      o_instrD <= word;
      o_pcD    <= pc_q;
      o_pc4D   <= pc_plus4;
      o_validD <= 1'b1;
    end else begin
      o_instrD <= NOP_INSTR;
      o_pcD    <= '0;
      o_pc4D   <= '0;
      o_validD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a table of per-cycle stimulus with
// expected combinational outputs (before the edge) and IF/ID contents (after
// the edge), followed by a hand-written async-reset-mid-WAIT sequence.
module tb_fetch_stage_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stallF, i_stallD, i_flushD, i_redirect;
  logic [31:0] i_redirect_pc;
  logic [6:0]  o_opcodeF;
  logic [31:0] o_instrD, o_pcD, o_pc4D;
  logic        o_validD;

  int passed = 0;
  int total  = 0;

  fetch_stage_ctrl_if bus ();

  fetch_stage_ctrl dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stallF      (i_stallF),
    .i_stallD      (i_stallD),
    .i_flushD      (i_flushD),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .imem          (bus.master),
    .o_opcodeF     (o_opcodeF),
    .o_instrD      (o_instrD),
    .o_pcD         (o_pcD),
    .o_pc4D        (o_pc4D),
    .o_validD      (o_validD)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  ctl;     // {stallF, stallD, flushD, redirect}
    logic [31:0] rpc;
    logic        ack;
    logic        rv;
    logic [31:0] rdata;
    logic        req;     // expected before the edge
    logic [31:0] addr;
    logic [6:0]  opc;
    logic [31:0] instr;   // expected after the edge
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        vld;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] rpc,
                              input logic ack, input logic rv, input logic [31:0] rdata,
                              input logic req, input logic [31:0] addr, input logic [6:0] opc,
                              input logic [31:0] instr, input logic [31:0] pcd,
                              input logic [31:0] pc4d, input logic vld);
    vec_t v;
    v.ctl = ctl; v.rpc = rpc; v.ack = ack; v.rv = rv; v.rdata = rdata;
    v.req = req; v.addr = addr; v.opc = opc;
    v.instr = instr; v.pcd = pcd; v.pc4d = pc4d; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  // Drive one cycle of stimulus, check outputs mid-cycle and IF/ID after the edge.
  task automatic step(input string tag, input vec_t v);
    {i_stallF, i_stallD, i_flushD, i_redirect} = v.ctl;
    i_redirect_pc = v.rpc;
    bus.ack       = v.ack;
    bus.rvalid    = v.rv;
    bus.rdata     = v.rdata;
    #2;
    chk({tag, " req"},  {31'd0, bus.req}, {31'd0, v.req});
    chk({tag, " addr"}, bus.addr, v.addr);
    chk({tag, " opcodeF"}, {25'd0, o_opcodeF}, {25'd0, v.opc});
    @(posedge i_clk);
    #1;
    chk({tag, " instrD"}, o_instrD, v.instr);
    chk({tag, " pcD"},    o_pcD, v.pcd);
    chk({tag, " pc4D"},   o_pc4D, v.pc4d);
    chk({tag, " validD"}, {31'd0, o_validD}, {31'd0, v.vld});
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NV = 25;
  vec_t vecs [0:NV-1];

  initial begin
    // ctl: {stallF, stallD, flushD, redirect}
    // Basic fetch from RESET_PC.
    vecs[0]  = mk(4'b0000, 0, 1, 0, 0,              1, 32'h0, 7'h00, NOP, 0, 0, 0);
    vecs[1]  = mk(4'b0000, 0, 0, 1, 32'h0050_0093,  0, 32'h0, 7'h13, 32'h0050_0093, 0, 4, 1);
    // Full stall: word parked in HOLD, IF/ID held, no request.
    vecs[2]  = mk(4'b1100, 0, 1, 0, 0,              1, 32'h4, 7'h00, 32'h0050_0093, 0, 4, 1);
    vecs[3]  = mk(4'b1100, 0, 0, 1, 32'h0020_8133,  0, 32'h4, 7'h33, 32'h0050_0093, 0, 4, 1);
    vecs[4]  = mk(4'b1100, 0, 0, 0, 0,              0, 32'h4, 7'h33, 32'h0050_0093, 0, 4, 1);
    vecs[5]  = mk(4'b0000, 0, 0, 0, 0,              0, 32'h4, 7'h33, 32'h0020_8133, 4, 8, 1);
    // stallF only: bubbles into ID while the JAL waits in HOLD.
    vecs[6]  = mk(4'b0000, 0, 1, 0, 0,              1, 32'h8, 7'h00, NOP, 0, 0, 0);
    vecs[7]  = mk(4'b1000, 0, 0, 1, 32'h0080_00EF,  0, 32'h8, 7'h6F, NOP, 0, 0, 0);
    vecs[8]  = mk(4'b1000, 0, 0, 0, 0,              0, 32'h8, 7'h6F, NOP, 0, 0, 0);
    vecs[9]  = mk(4'b0000, 0, 0, 0, 0,              0, 32'h8, 7'h6F, 32'h0080_00EF, 8, 32'hC, 1);
    // Redirect in WAIT before the response arrives; low PC bits forced to 0.
    vecs[10] = mk(4'b0000, 0, 1, 0, 0,              1, 32'hC, 7'h00, NOP, 0, 0, 0);
    vecs[11] = mk(4'b0001, 32'h103, 0, 0, 0,        0, 32'hC, 7'h00, NOP, 0, 0, 0);
    vecs[12] = mk(4'b0000, 0, 0, 1, 32'h0000_0033,  0, 32'h100, 7'h00, NOP, 0, 0, 0);
    vecs[13] = mk(4'b0000, 0, 0, 0, 0,              1, 32'h100, 7'h00, NOP, 0, 0, 0);
    // Redirect together with ack in REQ.
    vecs[14] = mk(4'b0001, 32'h200, 1, 0, 0,        1, 32'h100, 7'h00, NOP, 0, 0, 0);
    vecs[15] = mk(4'b0000, 0, 0, 1, 32'h0000_0013,  0, 32'h200, 7'h00, NOP, 0, 0, 0);
    vecs[16] = mk(4'b0000, 0, 1, 0, 0,              1, 32'h200, 7'h00, NOP, 0, 0, 0);
    vecs[17] = mk(4'b0000, 0, 0, 1, 32'h0010_0093,  0, 32'h200, 7'h13, 32'h0010_0093, 32'h200, 32'h204, 1);
    // stallD holds, flushD beats stallD, then held bubble.
    vecs[18] = mk(4'b0100, 0, 0, 0, 0,              1, 32'h204, 7'h00, 32'h0010_0093, 32'h200, 32'h204, 1);
    vecs[19] = mk(4'b0110, 0, 0, 0, 0,              1, 32'h204, 7'h00, NOP, 0, 0, 0);
    vecs[20] = mk(4'b0100, 0, 0, 0, 0,              1, 32'h204, 7'h00, NOP, 0, 0, 0);
    // Redirect to the top word; pc+4 wraps to zero.
    vecs[21] = mk(4'b0001, 32'hFFFF_FFFE, 0, 0, 0,  1, 32'h204, 7'h00, NOP, 0, 0, 0);
    vecs[22] = mk(4'b0000, 0, 1, 0, 0,              1, 32'hFFFF_FFFC, 7'h00, NOP, 0, 0, 0);
    vecs[23] = mk(4'b0000, 0, 0, 1, 32'h0000_0073,  0, 32'hFFFF_FFFC, 7'h73, 32'h0000_0073, 32'hFFFF_FFFC, 0, 1);
    vecs[24] = mk(4'b0100, 0, 1, 0, 0,              1, 32'h0, 7'h00, 32'h0000_0073, 32'hFFFF_FFFC, 0, 1);

    i_reset = 1'b1;
    {i_stallF, i_stallD, i_flushD, i_redirect} = 4'b0000;
    i_redirect_pc = '0;
    bus.ack = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;

    // Reset state.
    #3;
    chk("reset req",    {31'd0, bus.req}, 32'd0);
    chk("reset validD", {31'd0, o_validD}, 32'd0);
    chk("reset instrD", o_instrD, NOP);
    chk("reset pcD",    o_pcD, 32'd0);
    chk("reset pc4D",   o_pc4D, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    for (int i = 0; i < NV; i++) step($sformatf("row%0d", i), vecs[i]);

    // Async reset while a request is outstanding (state WAIT, IF/ID valid).
    {i_stallF, i_stallD, i_flushD, i_redirect} = 4'b0000;
    bus.ack = 1'b0; bus.rvalid = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    chk("async req",    {31'd0, bus.req}, 32'd0);
    chk("async validD", {31'd0, o_validD}, 32'd0);
    chk("async instrD", o_instrD, NOP);
    chk("async pcD",    o_pcD, 32'd0);
    chk("async pc4D",   o_pc4D, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    // Late response from before reset must be ignored: FSM is in REQ.
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0000_0033;
    #2;
    chk("late req",     {31'd0, bus.req}, 32'd1);
    chk("late addr",    bus.addr, 32'h0);
    chk("late opcodeF", {25'd0, o_opcodeF}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("late validD",  {31'd0, o_validD}, 32'd0);
    chk("late instrD",  o_instrD, NOP);
    step("post0", mk(4'b0000, 0, 1, 0, 0,             1, 32'h0, 7'h00, NOP, 0, 0, 0));
    step("post1", mk(4'b0000, 0, 0, 1, 32'h0050_0093, 0, 32'h0, 7'h13, 32'h0050_0093, 0, 4, 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
